// File: rtl/wb_stage_if.sv
// MEM -> WB pipeline bus: the instruction fields offered by the memory stage
// plus the write-back stage's allow-in back-pressure signal.
interface wb_stage_if;
    logic        me_valid;
    logic [31:0] me_pc;
    logic [31:0] me_inst;
    logic [11:0] me_wb_ctrl;
    logic [4:0]  me_waddr;
    logic [31:0] me_alu_out;
    logic [31:0] me_load_data;
    logic [31:0] me_hi;
    logic [31:0] me_lo;
    logic [3:0]  me_exc;
    logic [23:0] me_excode;
    logic        me_bd;
    logic        wb_allowin;

    // MEM side drives the instruction and listens to back-pressure.
    modport master (
        output me_valid, me_pc, me_inst, me_wb_ctrl, me_waddr, me_alu_out,
               me_load_data, me_hi, me_lo, me_exc, me_excode, me_bd,
        input  wb_allowin
    );

    // WB side consumes the instruction and drives back-pressure.
    modport slave (
        input  me_valid, me_pc, me_inst, me_wb_ctrl, me_waddr, me_alu_out,
               me_load_data, me_hi, me_lo, me_exc, me_excode, me_bd,
        output wb_allowin
    );
endinterface

// File: rtl/wb_stage.sv
// Write-back stage of the five-stage MIPS core: latches one instruction per
// cycle, drives the register-file write port, owns HI/LO, commits exceptions,
// counts retired instructions and drives the debug trace port.
module wb_stage #(
    parameter logic [31:0] RESET_PC = 32'hbfc00000,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             ext_stall,
    wb_stage_if.slave        me,
    output logic             rf_wen,
    output logic [4:0]       rf_waddr,
    output logic [31:0]      rf_wdata,
    output logic [31:0]      hi_o,
    output logic [31:0]      lo_o,
    output logic             exc_commit,
    output logic [31:0]      exc_epc,
    output logic [5:0]       exc_code,
    output logic             exc_bd,
    output logic [CNT_W-1:0] retired,
    output logic [31:0]      debug_wb_pc,
    output logic [3:0]       debug_wb_rf_wen,
    output logic [4:0]       debug_wb_rf_wnum,
    output logic [31:0]      debug_wb_rf_wdata
);

    // Fields held for the instruction currently in WB. The instruction word
    // and the reserved control bits have no effect here, so they are not kept.
    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  ctrl;      // [0] rf write, [2:1] result sel, [3] HI wr, [4] LO wr
        logic [4:0]  waddr;
        logic [31:0] alu_out;
        logic [31:0] load_data;
        logic [31:0] hi;
        logic [31:0] lo;
        logic [3:0]  exc;
        logic [23:0] excode;
        logic        bd;
    } wb_fields_t;

    wb_fields_t       wb_q;
    logic             wb_valid;
    logic [31:0]      hi_q;
    logic [31:0]      lo_q;
    logic [CNT_W-1:0] retired_q;

    logic wb_ready_go;
    logic complete;
    logic has_exc;
    logic retire;

    assign wb_ready_go   = !ext_stall;
    assign me.wb_allowin = !wb_valid || wb_ready_go;
    assign complete      = wb_valid && wb_ready_go;
    assign has_exc       = |wb_q.exc;
    assign retire        = complete && !has_exc;
    assign exc_commit    = complete && has_exc;

    // Pipeline register: capture on handshake, drop the offered instruction on a flush.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wb_valid <= 1'b0;
            wb_q     <= '0;
            wb_q.pc  <= RESET_PC;
        end else if (exc_commit) begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            wb_valid <= 1'b0;
        end else if (me.wb_allowin) begin
            wb_valid <= me.me_valid;
            if (me.me_valid) begin
                wb_q <= '{pc:        me.me_pc,
                          ctrl:      me.me_wb_ctrl[4:0],
                          waddr:     me.me_waddr,
                          alu_out:   me.me_alu_out,
                          load_data: me.me_load_data,
                          hi:        me.me_hi,
                          lo:        me.me_lo,
                          exc:       me.me_exc,
                          excode:    me.me_excode,
                          bd:        me.me_bd};
            end
        end
    end

    // Architectural HI/LO and retired counter update only when an instruction retires cleanly.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hi_q      <= '0;
            lo_q      <= '0;
            retired_q <= '0;
        end else if (retire) begin
            if (wb_q.ctrl[3]) hi_q <= wb_q.hi;
            if (wb_q.ctrl[4]) lo_q <= wb_q.lo;
            retired_q <= retired_q + CNT_W'(1);
        end
    end

    // Result select: HI/LO selections read the current architectural registers.
    always_comb begin
        // NOTE: default first so every path assigns rf_wdata and no latch is inferred.
        rf_wdata = wb_q.alu_out;
        case (wb_q.ctrl[2:1])
            2'b01:   rf_wdata = wb_q.load_data;
            2'b10:   rf_wdata = hi_q;
            2'b11:   rf_wdata = lo_q;
            default: rf_wdata = wb_q.alu_out;
        endcase
    end

    // Exception report: lowest-index flag wins; everything reads zero when not committing.
    always_comb begin
        exc_code = 6'd0;
        exc_epc  = 32'd0;
        exc_bd   = 1'b0;
        if (exc_commit) begin
            if (wb_q.exc[0])      exc_code = wb_q.excode[5:0];
            else if (wb_q.exc[1]) exc_code = wb_q.excode[11:6];
            else if (wb_q.exc[2]) exc_code = wb_q.excode[17:12];
            else                  exc_code = wb_q.excode[23:18];
            exc_bd  = wb_q.bd;
            exc_epc = wb_q.bd ? (wb_q.pc - 32'd4) : wb_q.pc;
        end
    end

    assign rf_wen            = retire && wb_q.ctrl[0] && (wb_q.waddr != 5'd0);
    assign rf_waddr          = wb_q.waddr;
    assign hi_o              = hi_q;
    assign lo_o              = lo_q;
    assign retired           = retired_q;
    assign debug_wb_pc       = wb_q.pc;
    assign debug_wb_rf_wen   = {4{rf_wen}};
    assign debug_wb_rf_wnum  = wb_q.waddr;
    assign debug_wb_rf_wdata = rf_wdata;

endmodule

// File: tb/tb_wb_stage.sv
// Testbench for wb_stage: directed instruction sequence, a transaction-level
// model compared against the DUT on every falling edge, and literal
// expectations taken from hand-worked cases.
module tb_wb_stage;

    localparam logic [31:0] RESET_PC = 32'hbfc00000;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        ext_stall = 1'b0;
    logic        rf_wen;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [31:0] hi_o;
    logic [31:0] lo_o;
    logic        exc_commit;
    logic [31:0] exc_epc;
    logic [5:0]  exc_code;
    logic        exc_bd;
    logic [31:0] retired;
    logic [31:0] debug_wb_pc;
    logic [3:0]  debug_wb_rf_wen;
    logic [4:0]  debug_wb_rf_wnum;
    logic [31:0] debug_wb_rf_wdata;

    wb_stage_if bus ();

    wb_stage #(.RESET_PC(RESET_PC), .CNT_W(32)) dut (
        .clk               (clk),
        .resetn            (resetn),
        .ext_stall         (ext_stall),
        .me                (bus.slave),
        .rf_wen            (rf_wen),
        .rf_waddr          (rf_waddr),
        .rf_wdata          (rf_wdata),
        .hi_o              (hi_o),
        .lo_o              (lo_o),
        .exc_commit        (exc_commit),
        .exc_epc           (exc_epc),
        .exc_code          (exc_code),
        .exc_bd            (exc_bd),
        .retired           (retired),
        .debug_wb_pc       (debug_wb_pc),
        .debug_wb_rf_wen   (debug_wb_rf_wen),
        .debug_wb_rf_wnum  (debug_wb_rf_wnum),
        .debug_wb_rf_wdata (debug_wb_rf_wdata)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    typedef struct {
        logic [31:0] pc;
        logic [11:0] ctrl;
        logic [4:0]  waddr;
        logic [31:0] alu;
        logic [31:0] load;
        logic [31:0] hi;
        logic [31:0] lo;
        logic [3:0]  exc;
        logic [23:0] excode;
        logic        bd;
    } instr_t;

    instr_t      m_cur;       // instruction most recently accepted into WB
    bit          m_busy;      // m_cur still waiting to leave WB
    logic [31:0] m_hi, m_lo, m_ret;

    function automatic instr_t bus_instr();
        instr_t t;
        t.pc = bus.me_pc;       t.ctrl = bus.me_wb_ctrl; t.waddr = bus.me_waddr;
        t.alu = bus.me_alu_out; t.load = bus.me_load_data;
        t.hi = bus.me_hi;       t.lo = bus.me_lo;
        t.exc = bus.me_exc;     t.excode = bus.me_excode; t.bd = bus.me_bd;
        return t;
    endfunction

    // Model step: the instruction in WB leaves if not stalled (retiring or trapping);
    // a trap throws away whatever MEM offers on the same edge.
    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_busy = 0; m_hi = 0; m_lo = 0; m_ret = 0;
            m_cur = '{pc: RESET_PC, default: '0};
        end else begin
            bit leaves, trapped;
            leaves  = m_busy && !ext_stall;
            trapped = leaves && (m_cur.exc != 0);
            if (leaves && !trapped) begin
                if (m_cur.ctrl[3]) m_hi = m_cur.hi;
                if (m_cur.ctrl[4]) m_lo = m_cur.lo;
                m_ret = m_ret + 1;
            end
            if (!m_busy || leaves) begin
                m_busy = 0;
                if (bus.me_valid && !trapped) begin
                    m_cur  = bus_instr();
                    m_busy = 1;
                end
            end
        end
    end

    bit cmp_en = 0;

    // Compare process: DUT outputs against the model, away from the rising edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            bit          leaving, trap, wr;
            logic [31:0] data, epc;
            logic [5:0]  code;
            bit          found;
            leaving = m_busy && !ext_stall;
            trap    = leaving && (m_cur.exc != 0);
            wr      = leaving && !trap && m_cur.ctrl[0] && (m_cur.waddr != 0);
            unique case (m_cur.ctrl[2:1])
                2'd0: data = m_cur.alu;
                2'd1: data = m_cur.load;
                2'd2: data = m_hi;
                default: data = m_lo;
            endcase
            code = 0; epc = 0; found = 0;
            if (trap) begin
                for (int i = 0; i < 4; i++)
                    if (m_cur.exc[i] && !found) begin
                        code  = m_cur.excode[6*i +: 6];
                        found = 1;
                    end
                epc = m_cur.bd ? m_cur.pc - 32'd4 : m_cur.pc;
            end
            check("cmp_allowin", bus.wb_allowin, !m_busy || !ext_stall);
            check("cmp_rf_wen", rf_wen, wr);
            check("cmp_rf_waddr", rf_waddr, m_cur.waddr);
            check("cmp_rf_wdata", rf_wdata, data);
            check("cmp_hi", hi_o, m_hi);
            check("cmp_lo", lo_o, m_lo);
            check("cmp_exc_commit", exc_commit, trap);
            check("cmp_exc_code", exc_code, code);
            check("cmp_exc_epc", exc_epc, epc);
            check("cmp_exc_bd", exc_bd, trap && m_cur.bd);
            check("cmp_retired", retired, m_ret);
            check("cmp_dbg_pc", debug_wb_pc, m_cur.pc);
            check("cmp_dbg_wen", debug_wb_rf_wen, {4{wr}});
            check("cmp_dbg_wnum", debug_wb_rf_wnum, m_cur.waddr);
            check("cmp_dbg_wdata", debug_wb_rf_wdata, data);
        end
    end

    // ---------------- stimulus ----------------
    task automatic offer(input logic v, input logic [31:0] pc, input logic [11:0] ctrl,
                         input logic [4:0] waddr, input logic [31:0] alu, input logic [31:0] load,
                         input logic [31:0] hi, input logic [31:0] lo, input logic [3:0] exc,
                         input logic [23:0] excode, input logic bd);
        bus.me_valid = v;       bus.me_pc = pc;         bus.me_inst = 32'h0;
        bus.me_wb_ctrl = ctrl;  bus.me_waddr = waddr;   bus.me_alu_out = alu;
        bus.me_load_data = load; bus.me_hi = hi;        bus.me_lo = lo;
        bus.me_exc = exc;       bus.me_excode = excode; bus.me_bd = bd;
    endtask

    task automatic idle();
        offer(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Advance one cycle; inputs change and literal checks run just after the falling edge.
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    initial begin
        int pulses;
        idle();
        resetn = 0;
        repeat (2) tick();
        resetn = 1;
        cmp_en = 1;

        // Reset state
        check("rst_rf_wen", rf_wen, 0);
        check("rst_hi", hi_o, 0);
        check("rst_lo", lo_o, 0);
        check("rst_retired", retired, 0);
        check("rst_dbg_pc", debug_wb_pc, 32'hbfc00000);
        check("rst_allowin", bus.wb_allowin, 1);

        // ALU write
        offer(1, 32'hbfc00000, 12'h001, 5, 32'h12345678, 0, 0, 0, 0, 0, 0);
        tick();
        idle();
        check("alu_rf_wen", rf_wen, 1);
        check("alu_waddr", rf_waddr, 5);
        check("alu_wdata", rf_wdata, 32'h12345678);
        check("alu_dbg_wen", debug_wb_rf_wen, 4'hf);
        tick();
        check("alu_retired", retired, 1);
        check("alu_wen_drop", rf_wen, 0);

        // mult then mfhi, mflo
        offer(1, 32'hbfc00004, 12'h018, 0, 0, 0, 32'haaaa0000, 32'h00005555, 0, 0, 0);
        tick();
        offer(1, 32'hbfc00008, 12'h005, 8, 32'h0, 0, 0, 0, 0, 0, 0);
        tick();
        check("mult_hi", hi_o, 32'haaaa0000);
        check("mult_lo", lo_o, 32'h00005555);
        check("mfhi_wdata", rf_wdata, 32'haaaa0000);
        check("mfhi_wen", rf_wen, 1);
        offer(1, 32'hbfc0000c, 12'h007, 9, 32'h0, 0, 0, 0, 0, 0, 0);
        tick();
        check("mflo_wdata", rf_wdata, 32'h00005555);

        // $0 write still retires
        offer(1, 32'hbfc00010, 12'h001, 0, 32'hffffffff, 0, 0, 0, 0, 0, 0);
        tick();
        idle();
        check("zero_rf_wen", rf_wen, 0);
        check("zero_retired_pre", retired, 4);
        tick();
        check("zero_retired_post", retired, 5);

        // Exception priority in a delay slot; instruction offered in the same cycle is dropped
        offer(1, 32'hbfc00104, 12'h019, 3, 32'h33, 0, 32'h11111111, 32'h22222222,
              4'b1010, 24'h140100, 1);
        tick();
        offer(1, 32'h80000000, 12'h001, 7, 32'h77, 0, 0, 0, 0, 0, 0);
        check("exc_commit", exc_commit, 1);
        check("exc_code", exc_code, 6'h04);
        check("exc_epc", exc_epc, 32'hbfc00100);
        check("exc_bd", exc_bd, 1);
        check("exc_rf_wen", rf_wen, 0);
        tick();
        idle();
        check("exc_pulse_end", exc_commit, 0);
        check("exc_code_zero", exc_code, 0);
        check("exc_epc_zero", exc_epc, 0);
        check("exc_hi_kept", hi_o, 32'haaaa0000);
        check("exc_lo_kept", lo_o, 32'h00005555);
        check("exc_retired", retired, 5);
        check("exc_dropped_pc", debug_wb_pc, 32'hbfc00104);
        check("exc_dropped_wen", rf_wen, 0);
        tick();

        // IF exception outranks all others, no delay slot
        offer(1, 32'hbfc00200, 12'h001, 4, 32'h1, 0, 0, 0, 4'b1111, 24'h8c52ca, 0);
        tick();
        idle();
        check("exc_if_code", exc_code, 6'h0a);
        check("exc_if_epc", exc_epc, 32'hbfc00200);
        check("exc_if_bd", exc_bd, 0);
        tick();

        // Stall for 3 cycles with a valid load, then exactly one write pulse
        ext_stall = 1;
        offer(1, 32'hbfc00300, 12'h003, 10, 32'h0, 32'hdeadbeef, 0, 0, 0, 0, 0);
        tick();
        idle();
        pulses = 0;
        for (int c = 0; c < 3; c++) begin
            check("stall_allowin", bus.wb_allowin, 0);
            check("stall_rf_wen", rf_wen, 0);
            tick();
        end
        ext_stall = 0;
        #1;
        for (int c = 0; c < 3; c++) begin
            if (rf_wen && rf_wdata == 32'hdeadbeef) pulses++;
            tick();
        end
        check("stall_pulses", pulses, 1);
        check("stall_retired", retired, 6);

        // Async reset between edges while stalled
        ext_stall = 1;
        offer(1, 32'hbfc00400, 12'h003, 12, 32'h0, 32'h5a5a5a5a, 0, 0, 0, 0, 0);
        tick();
        idle();
        #2;
        resetn = 0;
        #1;
        check("arst_allowin", bus.wb_allowin, 1);
        check("arst_hi", hi_o, 0);
        check("arst_lo", lo_o, 0);
        check("arst_retired", retired, 0);
        check("arst_dbg_pc", debug_wb_pc, 32'hbfc00000);
        check("arst_rf_wen", rf_wen, 0);
        tick();
        ext_stall = 0;
        resetn = 1;
        tick();
        check("post_rst_retired", retired, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
